branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//   Parametrised branch target buffer with 2-bit saturating direction counters.
//   Sits beside the instruction memory in IF. Each cycle it predicts the next PC
//   for the fetch PC, replacing the fixed pc+4 path. EX reports resolved
//   control-flow instructions back on the update port to train the table.
//   Two indexing modes: bimodal (PC-indexed) or gshare (PC XOR global history).
// PARAMETERS
//   ENTRIES   32  table depth; power of 2, >= 2; IDX = $clog2(ENTRIES)
//   GHR_BITS  5   global history length, 1..IDX; used only when MODE=1
//   MODE      0   0 = bimodal, 1 = gshare
// PORTS
//   clk             in   1    clock; all state updates on posedge
//   reset           in   1    synchronous, active-high; clears all state
//   lookup_pc       in   32   PC of the instruction being fetched (IF)
//   pred_hit        out  1    valid entry with matching tag at pred_index
//   pred_taken      out  1    pred_hit && counter[1]
//   pred_next_pc    out  32   pred_taken ? stored target : lookup_pc+4
//   pred_index      out  IDX  table index used; carried down the pipe to EX
//   update_valid    in   1    EX resolved a branch/jal/jalr this cycle
//   update_pc       in   32   PC of the resolved instruction
//   update_index    in   IDX  pred_index captured at that instruction's fetch
//   update_taken    in   1    actual direction (1 for jal/jalr)
//   update_target   in   32   actual target address
// BEHAVIOUR
//   - Entry: valid(1), tag(32-IDX-2 = pc[31:IDX+2]), target(32), ctr(2).
//   - Lookup is combinational, same cycle. Index: MODE0 = lookup_pc[IDX+1:2].
//     MODE1 = lookup_pc[IDX+1:2] ^ {zero-ext ghr}.
//   - Update on posedge when update_valid. Always writes at update_index, never
//     recomputes it. Tag compare: update_pc[31:IDX+2] vs stored tag.
//     * hit, taken     : ctr = sat_inc(ctr) (max 2'b11); target <= update_target
//     * hit, not taken : ctr = sat_dec(ctr) (min 2'b00); target kept
//     * miss, taken    : allocate. valid=1, tag, target, ctr=2'b10 (replaces
//                        any occupant)
//     * miss, not taken: table unchanged
//   - GHR (MODE=1 only): on update_valid, ghr <= {ghr[GHR_BITS-2:0],
//     update_taken}. The GHR is non-speculative. MODE0 keeps ghr at 0.
//   - Simultaneous lookup and update of the same entry: the lookup sees the
//     pre-edge contents. The new value is visible the cycle after the edge
//     (no bypass).
//   - Reset: all valid=0, ctr=2'b01, targets/tags=0, ghr=0. Reset wins over a
//     concurrent update_valid. Reset value of outputs, for any lookup_pc:
//     pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4, pred_index=pc bits.
//   - Arithmetic: pc+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//     Counters never wrap.
//   - Aliasing: different PCs with the same index but different tags are a miss.
//     Same tag, aliased via GHR in MODE1: accepted, trained normally.
//   - Latency: 0 cycles lookup; 1 cycle update-to-visible.
//   - No internal stall/flush. The CPU holds lookup_pc during a stall. Flushed
//     instructions must not assert update_valid.
// TESTING
//   1 After reset, lookup_pc=0x40 -> hit=0, taken=0, next_pc=0x44, for all
//     ENTRIES.
//   2 Update pc=0x40,taken=1,target=0x100 -> next cycle lookup 0x40: hit=1,
//     taken=1, next_pc=0x100; a further not-taken update gives ctr 01 and
//     taken=0.
//   3 Four taken updates saturate ctr=11; one not-taken -> still taken. Four
//     not-taken give ctr=00; the next not-taken keeps 00 (no wrap).
//   4 Alias: train 0x40, then look up 0x40+4*ENTRIES -> hit=0, next_pc=
//     lookup+4. A taken update at the alias evicts 0x40 (0x40 then misses).
//   5 MODE=1: updates T,T,N give ghr=3'b110 (low bits). pred_index for pc=0x40
//     = 0x10 ^ 0b110 = 0x16. A concurrent reset+update leaves ghr=0 and the
//     table empty.
//   6 Same-cycle lookup/update at one index: lookup returns the old entry this
//     cycle and the updated entry next cycle. Lookup 0xFFFFFFFC on a miss gives
//     next_pc=0x0.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Predicts the next fetch PC in the same cycle; trained by resolved branches from EX.

module bp_entry #(
    parameter int TAG_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_taken,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      target,
    output logic [1:0]       ctr
);
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      target_q, target_d;
    logic [1:0]       ctr_q, ctr_d;
    logic             tag_hit;

    assign tag_hit = valid_q && (tag_q == wr_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (wr_en) begin
            if (tag_hit) begin
                if (wr_taken) begin
                    ctr_d    = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'd1;
                    target_d = wr_target;
                end else begin
                    ctr_d = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'd1;
                end
            end else if (wr_taken) begin
                // Miss + taken allocates over whatever occupies this slot.
                valid_d  = 1'b1;
                tag_d    = wr_tag;
                target_d = wr_target;
                ctr_d    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= 2'b01;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    assign valid  = valid_q;
    assign tag    = tag_q;
    assign target = target_q;
    assign ctr    = ctr_q;
endmodule

module branch_predictor #(
    parameter int ENTRIES  = 32,
    parameter int GHR_BITS = 5,
    parameter int MODE     = 0,
    localparam int IDX     = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    lookup_pc,
    output logic           pred_hit,
    output logic           pred_taken,
    output logic [31:0]    pred_next_pc,
    output logic [IDX-1:0] pred_index,
    input  logic           update_valid,
    input  logic [31:0]    update_pc,
    input  logic [IDX-1:0] update_index,
    input  logic           update_taken,
    input  logic [31:0]    update_target
);
    localparam int TAG_W = 32 - IDX - 2;

    logic [GHR_BITS-1:0]               ghr_q, ghr_d;
    logic [ENTRIES-1:0]                ent_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]     ent_tag;
    logic [ENTRIES-1:0][31:0]          ent_target;
    logic [ENTRIES-1:0][1:0]           ent_ctr;
    logic [IDX-1:0]                    ghr_ext;
    logic [TAG_W-1:0]                  lookup_tag;
    logic [TAG_W-1:0]                  update_tag;
    logic                              unused_bits;

    // History is non-speculative: only resolved updates shift it in.
    always_comb begin
        ghr_d = ghr_q;
        if (MODE == 1 && update_valid)
            ghr_d = GHR_BITS'({ghr_q, update_taken});
    end

    always_ff @(posedge clk) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign ghr_ext    = (MODE == 1) ? IDX'(ghr_q) : '0;
    assign pred_index = lookup_pc[IDX+1:2] ^ ghr_ext;
    assign lookup_tag = lookup_pc[31:IDX+2];
    assign update_tag = update_pc[31:IDX+2];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        bp_entry #(.TAG_W(TAG_W)) u_ent (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (update_valid && (update_index == IDX'(i))),
            .wr_taken  (update_taken),
            .wr_tag    (update_tag),
            .wr_target (update_target),
            .valid     (ent_valid[i]),
            .tag       (ent_tag[i]),
            .target    (ent_target[i]),
            .ctr       (ent_ctr[i])
        );
    end

    // Reads see pre-edge state; no bypass from a same-cycle update.
    always_comb begin
        pred_hit     = ent_valid[pred_index] && (ent_tag[pred_index] == lookup_tag);
        pred_taken   = pred_hit && ent_ctr[pred_index][1];
        pred_next_pc = pred_taken ? ent_target[pred_index] : lookup_pc + 32'd4;
    end

    assign unused_bits = ^{lookup_pc[1:0], update_pc[IDX+1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor: a bimodal and a gshare instance
// run the same stimulus and are compared against a table-of-arrays reference model.

module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lpc, upc, utgt;
    logic        uv, ut;
    logic [4:0]  uidx0, uidx1;
    logic        hit0, tk0, hit1, tk1;
    logic [31:0] npc0, npc1;
    logic [4:0]  pidx0, pidx1;

    int n_vec = 0, n_cmp = 0, n_err = 0;

    // reference model: [0] bimodal, [1] gshare
    bit          m_valid[2][32];
    logic [31:0] m_tag[2][32];
    logic [31:0] m_tgt[2][32];
    int          m_ctr[2][32];
    int          m_ghr[2];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(32), .GHR_BITS(5), .MODE(0)) dut0 (
        .clk(clk), .reset(rst), .lookup_pc(lpc), .pred_hit(hit0), .pred_taken(tk0),
        .pred_next_pc(npc0), .pred_index(pidx0), .update_valid(uv), .update_pc(upc),
        .update_index(uidx0), .update_taken(ut), .update_target(utgt));

    branch_predictor #(.ENTRIES(32), .GHR_BITS(5), .MODE(1)) dut1 (
        .clk(clk), .reset(rst), .lookup_pc(lpc), .pred_hit(hit1), .pred_taken(tk1),
        .pred_next_pc(npc1), .pred_index(pidx1), .update_valid(uv), .update_pc(upc),
        .update_index(uidx1), .update_taken(ut), .update_target(utgt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input int d, input logic [31:0] pc);
        int i;
        i = int'((pc / 4) % 32);
        if (d == 1) i = i ^ m_ghr[1];
        return i;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[d][i] = 0;
                m_tag[d][i]   = 0;
                m_tgt[d][i]   = 0;
                m_ctr[d][i]   = 1;
            end
            m_ghr[d] = 0;
        end
    endtask

    task automatic model_update(input int d, input int i);
        if (m_valid[d][i] && m_tag[d][i] == upc / 128) begin
            if (ut) begin
                m_ctr[d][i] = (m_ctr[d][i] + 1 > 3) ? 3 : m_ctr[d][i] + 1;
                m_tgt[d][i] = utgt;
            end else begin
                m_ctr[d][i] = (m_ctr[d][i] - 1 < 0) ? 0 : m_ctr[d][i] - 1;
            end
        end else if (ut) begin
            m_valid[d][i] = 1;
            m_tag[d][i]   = upc / 128;
            m_tgt[d][i]   = utgt;
            m_ctr[d][i]   = 2;
        end
        if (d == 1) m_ghr[1] = (m_ghr[1] * 2 + int'(ut)) % 32;
    endtask

    task automatic model_check(input int d, input logic h, input logic t,
                               input logic [31:0] n, input logic [4:0] x);
        int  i;
        bit  eh, et;
        logic [31:0] en;
        i  = midx(d, lpc);
        eh = m_valid[d][i] && (m_tag[d][i] == lpc / 128);
        et = eh && (m_ctr[d][i] >= 2);
        en = et ? m_tgt[d][i] : lpc + 32'd4;
        chk($sformatf("m%0d_index", d), 32'(x), 32'(i));
        chk($sformatf("m%0d_hit", d), 32'(h), 32'(eh));
        chk($sformatf("m%0d_taken", d), 32'(t), 32'(et));
        chk($sformatf("m%0d_next_pc", d), n, en);
    endtask

    // Drive one cycle's inputs, then check combinational outputs against the model.
    task automatic step(input logic [31:0] l, input logic v, input logic [31:0] p,
                        input logic t, input logic [31:0] g);
        lpc = l; uv = v; upc = p; ut = t; utgt = g;
        uidx0 = 5'(midx(0, p));
        uidx1 = 5'(midx(1, p));
        n_vec++;
        #1;
        model_check(0, hit0, tk0, npc0, pidx0);
        model_check(1, hit1, tk1, npc1, pidx1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else if (uv) begin
            model_update(0, int'(uidx0));
            model_update(1, int'(uidx1));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc(input logic [31:0] l, input logic v, input logic [31:0] p,
                       input logic t, input logic [31:0] g);
        step(l, v, p, t, g);
        tick();
    endtask

    initial begin
        logic [31:0] rp;
        model_reset();
        rst = 1'b1;
        lpc = 0; uv = 0; upc = 0; ut = 0; utgt = 0; uidx0 = 0; uidx1 = 0;
        @(negedge clk);
        cyc(32'h40, 0, 0, 0, 0);

        // reset state
        step(32'h40, 0, 0, 0, 0);
        chk("rst_hit", 32'(hit0), 32'd0);
        chk("rst_next", npc0, 32'h44);
        tick();

        // allocate and predict, then weaken
        cyc(32'h40, 1, 32'h40, 1, 32'h100);
        step(32'h40, 0, 0, 0, 0);
        chk("alloc_taken", 32'(tk0), 32'd1);
        chk("alloc_next", npc0, 32'h100);
        tick();
        cyc(32'h40, 1, 32'h40, 0, 0);
        step(32'h40, 0, 0, 0, 0);
        chk("weak_hit", 32'(hit0), 32'd1);
        chk("weak_taken", 32'(tk0), 32'd0);
        tick();

        // saturation up and down
        for (int k = 0; k < 4; k++) cyc(32'h0, 1, 32'h40, 1, 32'h100);
        cyc(32'h0, 1, 32'h40, 0, 0);
        step(32'h40, 0, 0, 0, 0);
        chk("sat_hi_taken", 32'(tk0), 32'd1);
        tick();
        for (int k = 0; k < 5; k++) cyc(32'h0, 1, 32'h40, 0, 0);
        cyc(32'h0, 1, 32'h40, 1, 32'h100);
        step(32'h40, 0, 0, 0, 0);
        chk("sat_lo_taken", 32'(tk0), 32'd0);
        tick();

        // alias eviction
        step(32'hC0, 0, 0, 0, 0);
        chk("alias_hit", 32'(hit0), 32'd0);
        chk("alias_next", npc0, 32'hC4);
        tick();
        cyc(32'h0, 1, 32'hC0, 1, 32'h300);
        step(32'h40, 0, 0, 0, 0);
        chk("evicted_hit", 32'(hit0), 32'd0);
        tick();
        step(32'hC0, 0, 0, 0, 0);
        chk("alias_new_next", npc0, 32'h300);
        tick();

        // gshare history and reset-wins
        rst = 1'b1; cyc(32'h0, 0, 0, 0, 0);
        cyc(32'h0, 1, 32'h200, 1, 32'h800);
        cyc(32'h0, 1, 32'h300, 1, 32'h900);
        cyc(32'h0, 1, 32'h404, 0, 0);
        step(32'h40, 0, 0, 0, 0);
        chk("gshare_index", 32'(pidx1), 32'h16);
        tick();
        rst = 1'b1; cyc(32'h0, 1, 32'h40, 1, 32'h500);
        step(32'h40, 0, 0, 0, 0);
        chk("rst_upd_index", 32'(pidx1), 32'h10);
        chk("rst_upd_hit", 32'(hit1), 32'd0);
        tick();

        // same-cycle lookup/update, and pc+4 wrap
        rst = 1'b1; cyc(32'h0, 0, 0, 0, 0);
        cyc(32'h0, 1, 32'h40, 1, 32'h100);
        step(32'h40, 1, 32'h40, 0, 0);
        chk("same_old_taken", 32'(tk0), 32'd1);
        chk("same_old_next", npc0, 32'h100);
        tick();
        step(32'h40, 0, 0, 0, 0);
        chk("same_new_taken", 32'(tk0), 32'd0);
        tick();
        step(32'hFFFF_FFFC, 0, 0, 0, 0);
        chk("wrap_next", npc0, 32'h0);
        tick();

        // random traffic over a small PC pool to provoke hits and aliasing
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            lpc = 32'h1000 * $urandom_range(0, 2) + 4 * $urandom_range(0, 40);
            if ($urandom_range(0, 30) == 0) lpc = 32'hFFFF_FFFC;
            rp = 32'h1000 * $urandom_range(0, 2) + 4 * $urandom_range(0, 40);
            cyc(lpc, ($urandom_range(0, 9) < 6), rp, $urandom_range(0, 1) == 1,
                $urandom & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
